// File: rtl/awg_waveform_engine.sv
// DDS waveform engine: phase accumulator, wave shaping, gain and offset with saturation.
// Latency 3 edges from a sampled tick to dac_valid. No backpressure; one sample per tick, back-to-back ticks accepted.
module awg_waveform_engine #(
    parameter int PHASE_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic [1:0]  waveform_type,
    input  logic [15:0] frequency,
    input  logic [9:0]  amplitude,
    input  logic [9:0]  dc_offset,
    output logic [9:0]  dac_data,
    output logic        dac_valid,
    output logic        phase_wrap
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         wf_q, wf_d;
    logic [15:0]        freq_q, freq_d;
    logic [9:0]         amp_q, amp_d, off_q, off_d;
    logic               en_q;
    logic               wrap_q, wrap_d;
    logic               v1_q, v1_d, v2_q, v2_d;
    logic [11:0]        s1_q, s1_d;
    logic [9:0]         amp1_q, amp1_d, off1_q, off1_d;
    logic [12:0]        m2_q, m2_d;
    logic [9:0]         off2_q, off2_d;
    logic [9:0]         dac_data_q, dac_data_d;
    logic               dac_valid_q, dac_valid_d;

    // Until the first enabled edge has passed, the inputs drive the datapath directly.
    logic [1:0]         wf_e;
    logic [15:0]        freq_e;
    logic [9:0]         amp_e, off_e;
    logic               tick, carry, load;
    logic [PHASE_W:0]   acc;
    logic [9:0]         p;
    logic [8:0]         x, h;
    logic [15:0]        para;
    logic [11:0]        s_w;
    logic signed [22:0] mult;
    logic signed [13:0] y;
    logic [9:0]         y_sat;

    always_comb begin
        wf_e   = en_q ? wf_q   : waveform_type;
        freq_e = en_q ? freq_q : frequency;
        amp_e  = en_q ? amp_q  : amplitude;
        off_e  = en_q ? off_q  : dc_offset;
        tick   = enable & sample_tick;
        acc    = {1'b0, phase_q} + (PHASE_W+1)'(freq_e);
        carry  = acc[PHASE_W];
        load   = !enable || !en_q || (tick && carry);
        p      = phase_q[PHASE_W-1 -: 10];
    end

    // Parabolic sine: x*(511-x)/128 peaks at 510 mid half-period.
    always_comb begin
        x    = p[8:0];
        para = {7'd0, x} * {7'd0, 9'd511 - x};
        h    = 9'(para >> 7);
        case (wf_e)
            2'b00:   s_w = p[9] ? 12'd0 - {3'b000, h} : {3'b000, h};
            2'b01:   s_w = p[9] ? 12'hE00 : 12'd511;
            2'b10:   s_w = p[9] ? 12'd1534 - {1'b0, p, 1'b0} : {1'b0, p, 1'b0} - 12'd512;
            default: s_w = {2'b00, p} - 12'd512;
        endcase
    end

    always_comb begin
        mult  = 23'($signed(s1_q)) * 23'($signed({1'b0, amp1_q}));
        y     = 14'($signed(m2_q)) + $signed({4'b0000, off2_q});
        if (y[13])
            y_sat = 10'd0;
        else if (y[12:10] != 3'd0)
            y_sat = 10'h3FF;
        else
            y_sat = y[9:0];
    end

    always_comb begin
        phase_d     = phase_q;
        wf_d        = wf_q;
        freq_d      = freq_q;
        amp_d       = amp_q;
        off_d       = off_q;
        wrap_d      = 1'b0;
        v1_d        = 1'b0;
        v2_d        = 1'b0;
        s1_d        = s1_q;
        amp1_d      = amp1_q;
        off1_d      = off1_q;
        m2_d        = m2_q;
        off2_d      = off2_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        if (load) begin
            wf_d   = waveform_type;
            freq_d = frequency;
            amp_d  = amplitude;
            off_d  = dc_offset;
        end
        if (!enable) begin
            phase_d    = '0;
            dac_data_d = off_q;
        end else begin
            v1_d        = tick;
            v2_d        = v1_q;
            dac_valid_d = v2_q;
            if (tick) begin
                phase_d = acc[PHASE_W-1:0];
                wrap_d  = carry;
                s1_d    = s_w;
                amp1_d  = amp_e;
                off1_d  = off_e;
            end
            if (v1_q) begin
                m2_d   = 13'(mult >>> 10);
                off2_d = off1_q;
            end
            if (v2_q)
                dac_data_d = y_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            wf_q        <= 2'b00;
            freq_q      <= 16'h0001;
            amp_q       <= 10'h3FF;
            off_q       <= 10'h200;
            en_q        <= 1'b0;
            wrap_q      <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_q        <= '0;
            amp1_q      <= '0;
            off1_q      <= '0;
            m2_q        <= '0;
            off2_q      <= '0;
            dac_data_q  <= 10'h200;
            dac_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wf_q        <= wf_d;
            freq_q      <= freq_d;
            amp_q       <= amp_d;
            off_q       <= off_d;
            en_q        <= enable;
            wrap_q      <= wrap_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_q        <= s1_d;
            amp1_q      <= amp1_d;
            off1_q      <= off1_d;
            m2_q        <= m2_d;
            off2_q      <= off2_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign dac_data   = dac_data_q;
    assign dac_valid  = dac_valid_q;
    assign phase_wrap = wrap_q;

endmodule

// File: tb/tb_awg_waveform_engine.sv
// Bench for awg_waveform_engine at PHASE_W=16: directed scenarios plus random traffic against a sample-level model.
module tb_awg_waveform_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic [1:0]  waveform_type = 2'd0;
    logic [15:0] frequency = 16'h0001;
    logic [9:0]  amplitude = 10'h3FF;
    logic [9:0]  dc_offset = 10'h200;
    logic [9:0]  dac_data;
    logic        dac_valid;
    logic        phase_wrap;

    awg_waveform_engine #(.PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
        .waveform_type(waveform_type), .frequency(frequency),
        .amplitude(amplitude), .dc_offset(dc_offset),
        .dac_data(dac_data), .dac_valid(dac_valid), .phase_wrap(phase_wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state
    int m_phase, m_wf, m_freq, m_amp, m_off, cyc_n;
    bit m_en_prev, exp_vld, exp_wrap;
    int exp_data;
    int q_due[$];
    int q_val[$];

    // directed-run bookkeeping
    int got[$];
    int wraps, run_idx, first_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sample(int p, int wf, int amp, int off);
        int s, x, h, prod, m, yv;
        case (wf)
            0: begin
                x = p % 512;
                h = (x * (511 - x)) / 128;
                s = (p >= 512) ? -h : h;
            end
            1: s = (p >= 512) ? -512 : 511;
            2: s = (p < 512) ? 2 * p - 512 : 1534 - 2 * p;
            default: s = p - 512;
        endcase
        prod = s * amp;
        if (prod >= 0) m = prod / 1024;
        else m = -((-prod + 1023) / 1024);
        yv = m + off;
        if (yv < 0) yv = 0;
        if (yv > 1023) yv = 1023;
        return yv;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_wf = 0; m_freq = 1; m_amp = 'h3FF; m_off = 'h200;
        m_en_prev = 0; exp_data = 'h200; exp_vld = 0; exp_wrap = 0;
        q_due.delete(); q_val.delete();
    endtask

    task automatic model_load();
        m_wf = waveform_type; m_freq = frequency; m_amp = amplitude; m_off = dc_offset;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_edge();
        int wf_e, fr_e, amp_e, off_e, nxt;
        cyc_n++;
        exp_vld = 0;
        exp_wrap = 0;
        if (!enable) begin
            m_phase = 0;
            q_due.delete(); q_val.delete();
            exp_data = m_off;
            model_load();
        end else begin
            wf_e  = m_en_prev ? m_wf   : int'(waveform_type);
            fr_e  = m_en_prev ? m_freq : int'(frequency);
            amp_e = m_en_prev ? m_amp  : int'(amplitude);
            off_e = m_en_prev ? m_off  : int'(dc_offset);
            if (sample_tick) begin
                q_due.push_back(cyc_n + 2);
                q_val.push_back(ref_sample(m_phase / 64, wf_e, amp_e, off_e));
                nxt = m_phase + fr_e;
                exp_wrap = (nxt >= 65536);
                m_phase = nxt % 65536;
            end
            if (!m_en_prev || exp_wrap) model_load();
            if (q_due.size() > 0 && q_due[0] == cyc_n) begin
                exp_vld = 1;
                exp_data = q_val[0];
                void'(q_due.pop_front());
                void'(q_val.pop_front());
            end
        end
        m_en_prev = enable;
    endtask

    task automatic cyc(input logic en, input logic st);
        enable = en;
        sample_tick = st;
        @(posedge clk);
        model_edge();
        #1;
        check("dac_valid", 32'(dac_valid), 32'(exp_vld));
        check("dac_data", 32'(dac_data), 32'(exp_data));
        check("phase_wrap", 32'(phase_wrap), 32'(exp_wrap));
        if (dac_valid) begin
            got.push_back(int'(dac_data));
            if (first_vld < 0) first_vld = run_idx;
        end
        if (phase_wrap) wraps++;
        run_idx++;
    endtask

    task automatic begin_run();
        got.delete();
        wraps = 0;
        run_idx = 0;
        first_vld = -1;
    endtask

    task automatic config_idle(input int wf, input int fr, input int amp, input int off);
        waveform_type = 2'(wf);
        frequency = 16'(fr);
        amplitude = 10'(amp);
        dc_offset = 10'(off);
        repeat (3) cyc(0, 0);
        begin_run();
    endtask

    int exp5[8] = '{1022, 1022, 0, 0, 0, 256, 512, 767};
    int n_before;

    initial begin
        cyc_n = 0;
        model_reset();
        begin_run();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(dac_data), 32'h200);
        check("rst_valid", 32'(dac_valid), 32'd0);
        check("rst_wrap", 32'(phase_wrap), 32'd0);
        rst = 1'b0;
        repeat (2) cyc(0, 0);
        check("idle_data", 32'(dac_data), 32'h200);

        // square, freq 1/4 cycle per tick
        config_idle(1, 'h4000, 'h3FF, 'h200);
        repeat (12) cyc(1, 1);
        check("sq_first_valid_idx", 32'(first_vld), 32'd2);
        check("sq_wraps", 32'(wraps), 32'd3);
        for (int i = 0; i < 8; i++)
            check("sq_sample", 32'(got[i]), (i % 4 < 2) ? 32'd1022 : 32'd0);

        // sawtooth at half gain
        config_idle(3, 'h4000, 'h200, 'h200);
        repeat (10) cyc(1, 1);
        check("saw_s0", 32'(got[0]), 32'd256);
        check("saw_s1", 32'(got[1]), 32'd384);
        check("saw_s2", 32'(got[2]), 32'd512);
        check("saw_s3", 32'(got[3]), 32'd640);
        check("saw_s4", 32'(got[4]), 32'd256);

        // sine, second sample at p=128
        config_idle(0, 'h2000, 'h3FF, 'h200);
        repeat (4) cyc(1, 1);
        check("sine_s0", 32'(got[0]), 32'd512);
        check("sine_s1", 32'(got[1]), 32'd894);

        // square with top offset: clamps high
        config_idle(1, 'h4000, 'h3FF, 'h3FF);
        repeat (6) cyc(1, 1);
        check("clamp_hi0", 32'(got[0]), 32'd1023);
        check("clamp_hi1", 32'(got[1]), 32'd1023);
        check("clamp_lo2", 32'(got[2]), 32'd511);
        check("clamp_lo3", 32'(got[3]), 32'd511);

        // zero gain
        config_idle(1, 'h4000, 0, 'h3FF);
        repeat (6) cyc(1, 1);
        for (int i = 0; i < 4; i++)
            check("amp0_sample", 32'(got[i]), 32'd1023);

        // waveform change mid-period takes effect only after the wrap
        config_idle(1, 'h4000, 'h3FF, 'h200);
        repeat (2) cyc(1, 1);
        waveform_type = 2'd3;
        repeat (8) cyc(1, 1);
        check("wfchg_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check("wfchg_sample", 32'(got[i]), 32'(exp5[i]));

        // drop enable with samples in flight
        config_idle(3, 'h4000, 'h3FF, 'h2F0);
        repeat (5) cyc(1, 1);
        n_before = got.size();
        repeat (4) cyc(0, 0);
        check("drop_no_valid", 32'(got.size()), 32'(n_before));
        check("drop_idle_data", 32'(dac_data), 32'h2F0);
        begin_run();
        cyc(1, 1);
        repeat (2) cyc(1, 0);
        check("reen_phase0", 32'(got[0]), 32'd240);

        // async reset mid-stream
        repeat (4) cyc(1, 1);
        check("pre_rst_valid", 32'(dac_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_data", 32'(dac_data), 32'h200);
        check("arst_valid", 32'(dac_valid), 32'd0);
        check("arst_wrap", 32'(phase_wrap), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cyc(0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                waveform_type = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: frequency = 16'd0;
                    1: frequency = 16'($urandom_range(1, 255));
                    default: frequency = 16'($urandom);
                endcase
                amplitude = 10'($urandom);
                dc_offset = 10'($urandom);
            end
            cyc(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
